// File: rtl/ip_rx_pkg.sv
// ip_rx_pkg
//   Shared definitions for the Ethernet/IPv4 receive parser: FSM state
//   encodings, protocol constants, header field byte offsets and a
//   one's-complement add helper used by the optional checksum unit.
//   No ports (package).
package ip_rx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ETH_HDR = 3'd1;
  localparam state_t ST_IP_HDR  = 3'd2;
  localparam state_t ST_PAYLOAD = 3'd3;
  localparam state_t ST_OUTPUT  = 3'd4;
  localparam state_t ST_DRAIN   = 3'd5;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [47:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF;

  // Byte offsets inside the Ethernet header
  localparam int ETH_DST_MAC_OFS = 0;
  localparam int ETH_SRC_MAC_OFS = 6;
  localparam int ETH_TYPE_OFS    = 12;

  // Byte offsets inside the IPv4 header
  localparam int IP_SRC_IP_OFS = 12;
  localparam int IP_DST_IP_OFS = 16;

  // 16-bit one's-complement addition with end-around carry
  function automatic logic [15:0] onesAdd16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/ip_rx_csum.sv
// ip_rx_csum
//   Incremental IPv4 header checksum accumulator. Bytes arrive big-endian;
//   an even byte is held as the high half of a word, the following odd byte
//   completes the word and folds it into the running one's-complement sum.
//   Only built when IP_RX_CSUM_CHECK_EN is defined.
// Ports
//   clk_i      clock
//   rst_i      asynchronous reset, active-high
//   clear_i    synchronous clear of the running sum
//   byteEn_i   a header byte is being accepted
//   byteOdd_i  the accepted byte is the low half of a word
//   data_i     header byte
//   sum_o      running sum including the current word when byteOdd_i is set
`ifdef IP_RX_CSUM_CHECK_EN
module ip_rx_csum
  import ip_rx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        byteEn_i,
  input  logic        byteOdd_i,
  input  logic [7:0]  data_i,
  output logic [15:0] sum_o
);

  logic [15:0] sum_q;
  logic [7:0]  hi_q;

  assign sum_o = byteOdd_i ? onesAdd16(sum_q, {hi_q, data_i}) : sum_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q <= '0;
      hi_q  <= '0;
    end else if (clear_i) begin
      sum_q <= '0;
      hi_q  <= '0;
    end else if (byteEn_i) begin
      if (byteOdd_i) sum_q <= sum_o;
      else           hi_q  <= data_i;
    end
  end

endmodule
`endif

// File: rtl/ip_packet_rx_filtered.sv
// ip_packet_rx_filtered
//   Ethernet/IPv4 receive parser between the MAC AXI-Stream RX port and the
//   accelerator. Strips the ETH and IP headers, filters on destination MAC
//   (own or broadcast), ethertype IPv4 and destination IP, requires an exact
//   payload length with a clean tlast, and hands one payload frame to the
//   accelerator with valid/ready. Accepted and dropped packets are counted
//   with saturating counters.
//   Optional: define IP_RX_CSUM_CHECK_EN to also drop packets whose IPv4
//   header checksum does not verify.
// Ports
//   ACLK, ARESET                       clock, async active-high reset
//   ACCELERATOR_IP_ADDRESS/MAC_ADDRESS own addresses (static)
//   MAC_DATA_OUT/VALID/READY/LAST/TUSER  AXI-S byte stream from the MAC
//   DATA_FRAME                         payload, byte i at [8i+7:8i]
//   SRC_IP_ADDRESS, SRC_MAC_ADDRESS    sender addresses of the held frame
//   FRAME_VALID, FRAME_READY           frame handshake to the accelerator
//   PKT_COUNT, DROP_COUNT              accepted / dropped packet counters
module ip_packet_rx_filtered
  import ip_rx_pkg::*;
#(
  parameter int ETH_HDR_BYTES = 14,
  parameter int IP_HDR_BYTES  = 20,
  parameter int PAYLOAD_BYTES = 785,
  parameter int CNT_W         = 16
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [31:0]                ACCELERATOR_IP_ADDRESS,
  input  logic [47:0]                ACCELERATOR_MAC_ADDRESS,
  input  logic [7:0]                 MAC_DATA_OUT,
  input  logic                       MAC_DATA_VALID,
  output logic                       MAC_DATA_READY,
  input  logic                       MAC_DATA_LAST,
  input  logic                       MAC_DATA_TUSER,
  output logic [8*PAYLOAD_BYTES-1:0] DATA_FRAME,
  output logic [31:0]                SRC_IP_ADDRESS,
  output logic [47:0]                SRC_MAC_ADDRESS,
  output logic                       FRAME_VALID,
  input  logic                       FRAME_READY,
  output logic [CNT_W-1:0]           PKT_COUNT,
  output logic [CNT_W-1:0]           DROP_COUNT
);

  localparam logic [CNT_W-1:0] ETH_LAST_IDX = CNT_W'(ETH_HDR_BYTES - 1);
  localparam logic [CNT_W-1:0] IP_LAST_IDX  = CNT_W'(IP_HDR_BYTES - 1);
  localparam logic [CNT_W-1:0] PAY_LAST_IDX = CNT_W'(PAYLOAD_BYTES - 1);
  localparam logic [CNT_W-1:0] PAY_BYTES_C  = CNT_W'(PAYLOAD_BYTES);
  localparam int               PIDX_W       = $clog2(PAYLOAD_BYTES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             frameValid_q, frameValid_d;
  logic [CNT_W-1:0] pktCnt_q, pktCnt_d;
  logic [CNT_W-1:0] dropCnt_q, dropCnt_d;

  logic [47:0]                dstMac_q;
  logic [47:0]                srcMac_q;
  logic [7:0]                 etherHi_q;
  logic [31:0]                srcIp_q;
  logic [23:0]                dstIpHi_q;
  logic [8*PAYLOAD_BYTES-1:0] payload_q;

  logic             beat;
  logic [CNT_W-1:0] ethIdx;
  logic [PIDX_W-1:0] payIdx;
  logic             macOk, typeOk, ipOk, csumOk;
  logic             acceptPkt, dropPkt;

  assign beat   = MAC_DATA_VALID & ready_q;
  // Byte 0 is taken in IDLE and the counter restarts on entering ETH_HDR,
  // so inside ETH_HDR the header byte index is one ahead of the counter.
  assign ethIdx = (state_q == ST_IDLE) ? '0 : cnt_q + 1'b1;
  assign payIdx = cnt_q[PIDX_W-1:0];

  // Last-byte checks combine the stored bytes with the byte on the bus
  assign macOk  = (dstMac_q == ACCELERATOR_MAC_ADDRESS) || (dstMac_q == BCAST_MAC);
  assign typeOk = ({etherHi_q, MAC_DATA_OUT} == ETHERTYPE_IPV4);
  assign ipOk   = ({dstIpHi_q, MAC_DATA_OUT} == ACCELERATOR_IP_ADDRESS);

`ifdef IP_RX_CSUM_CHECK_EN
  logic [15:0] csumSum;

  ip_rx_csum u_csum (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .clear_i   (state_q != ST_IP_HDR),
    .byteEn_i  (beat && (state_q == ST_IP_HDR)),
    .byteOdd_i (cnt_q[0]),
    .data_i    (MAC_DATA_OUT),
    .sum_o     (csumSum)
  );

  assign csumOk = (csumSum == 16'hFFFF);
`else
  assign csumOk = 1'b1;
`endif

  // Packet FSM, counters and the registered tready
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frameValid_d = frameValid_q;
    acceptPkt    = 1'b0;
    dropPkt      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (beat) begin
          if (MAC_DATA_LAST) dropPkt = 1'b1;
          else               state_d = ST_ETH_HDR;
        end
      end
      ST_ETH_HDR: begin
        if (beat) begin
          if (ethIdx == ETH_LAST_IDX) begin
            if (macOk && typeOk && !MAC_DATA_LAST) state_d = ST_IP_HDR;
            else                                   dropPkt = 1'b1;
          end else if (MAC_DATA_LAST) begin
            dropPkt = 1'b1;
          end
        end
      end
      ST_IP_HDR: begin
        if (beat) begin
          if (cnt_q == IP_LAST_IDX) begin
            if (ipOk && csumOk && !MAC_DATA_LAST) state_d = ST_PAYLOAD;
            else                                  dropPkt = 1'b1;
          end else if (MAC_DATA_LAST) begin
            dropPkt = 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (beat) begin
          if (cnt_q == PAY_LAST_IDX) begin
            if (MAC_DATA_LAST && !MAC_DATA_TUSER) acceptPkt = 1'b1;
            else                                  dropPkt   = 1'b1;
          end else if (MAC_DATA_LAST) begin
            dropPkt = 1'b1;
          end
        end
      end
      ST_OUTPUT: begin
        if (FRAME_READY) begin
          state_d      = ST_IDLE;
          frameValid_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (beat && MAC_DATA_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (acceptPkt) begin
      state_d      = ST_OUTPUT;
      frameValid_d = 1'b1;
    end
    // A drop that already sees tlast has nothing left to discard
    if (dropPkt) state_d = MAC_DATA_LAST ? ST_IDLE : ST_DRAIN;

    if (state_d != state_q)
      cnt_d = '0;
    else if (beat && (state_q == ST_ETH_HDR || state_q == ST_IP_HDR || state_q == ST_PAYLOAD))
      cnt_d = cnt_q + 1'b1;

    pktCnt_d  = (acceptPkt && pktCnt_q  != '1) ? pktCnt_q  + 1'b1 : pktCnt_q;
    dropCnt_d = (dropPkt   && dropCnt_q != '1) ? dropCnt_q + 1'b1 : dropCnt_q;

    case (state_d)
      ST_IDLE:   ready_d = !frameValid_d;
      ST_OUTPUT: ready_d = 1'b0;
      default:   ready_d = 1'b1;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      frameValid_q <= 1'b0;
      pktCnt_q     <= '0;
      dropCnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      frameValid_q <= frameValid_d;
      pktCnt_q     <= pktCnt_d;
      dropCnt_q    <= dropCnt_d;
    end
  end

  // Header field and payload stores; only the fields used later are kept.
  // No beat is accepted while a frame is held, so the outputs stay stable.
  always_ff @(posedge ACLK) begin
    if (beat && (state_q == ST_IDLE || state_q == ST_ETH_HDR)) begin
      for (int k = 0; k < 6; k++) begin
        if (ethIdx == CNT_W'(ETH_DST_MAC_OFS + k)) dstMac_q[8*(5-k) +: 8] <= MAC_DATA_OUT;
        if (ethIdx == CNT_W'(ETH_SRC_MAC_OFS + k)) srcMac_q[8*(5-k) +: 8] <= MAC_DATA_OUT;
      end
      if (ethIdx == CNT_W'(ETH_TYPE_OFS)) etherHi_q <= MAC_DATA_OUT;
    end
    if (beat && state_q == ST_IP_HDR) begin
      for (int k = 0; k < 4; k++)
        if (cnt_q == CNT_W'(IP_SRC_IP_OFS + k)) srcIp_q[8*(3-k) +: 8] <= MAC_DATA_OUT;
      for (int k = 0; k < 3; k++)
        if (cnt_q == CNT_W'(IP_DST_IP_OFS + k)) dstIpHi_q[8*(2-k) +: 8] <= MAC_DATA_OUT;
    end
    if (beat && state_q == ST_PAYLOAD && cnt_q < PAY_BYTES_C)
      payload_q[8*payIdx +: 8] <= MAC_DATA_OUT;
  end

  assign MAC_DATA_READY  = ready_q;
  assign FRAME_VALID     = frameValid_q;
  assign DATA_FRAME      = payload_q;
  assign SRC_IP_ADDRESS  = srcIp_q;
  assign SRC_MAC_ADDRESS = srcMac_q;
  assign PKT_COUNT       = pktCnt_q;
  assign DROP_COUNT      = dropCnt_q;

endmodule

// File: tb/tb_ip_packet_rx_filtered.sv
// tb_ip_packet_rx_filtered
//   Self-checking bench for ip_packet_rx_filtered. Packets are built as byte
//   queues with random fields and payload, streamed with random bubbles, and
//   the outcome (accept/drop, frame contents, sender addresses, counters) is
//   predicted from the packet bytes alone by a reference model.
//   Honours IP_RX_CSUM_CHECK_EN in the model when the design is built with it.
module tb_ip_packet_rx_filtered;

  localparam int PAYLOAD_BYTES = 785;
  localparam int CNT_W         = 16;
  localparam int HDR_BYTES     = 34;
  localparam int PKT_BYTES     = HDR_BYTES + PAYLOAD_BYTES;
  localparam int CNT_MAX       = (1 << CNT_W) - 1;

  typedef logic [7:0] byteQ_t [$];

  logic                       ACLK = 1'b0;
  logic                       ARESET;
  logic [31:0]                ownIp  = 32'hC0A8_0A05;
  logic [47:0]                ownMac = 48'h0200_0000_0042;
  logic [7:0]                 MAC_DATA_OUT;
  logic                       MAC_DATA_VALID;
  logic                       MAC_DATA_READY;
  logic                       MAC_DATA_LAST;
  logic                       MAC_DATA_TUSER;
  logic [8*PAYLOAD_BYTES-1:0] DATA_FRAME;
  logic [31:0]                SRC_IP_ADDRESS;
  logic [47:0]                SRC_MAC_ADDRESS;
  logic                       FRAME_VALID;
  logic                       FRAME_READY;
  logic [CNT_W-1:0]           PKT_COUNT;
  logic [CNT_W-1:0]           DROP_COUNT;

  always #5 ACLK = ~ACLK;

  ip_packet_rx_filtered dut (
    .ACLK                    (ACLK),
    .ARESET                  (ARESET),
    .ACCELERATOR_IP_ADDRESS  (ownIp),
    .ACCELERATOR_MAC_ADDRESS (ownMac),
    .MAC_DATA_OUT            (MAC_DATA_OUT),
    .MAC_DATA_VALID          (MAC_DATA_VALID),
    .MAC_DATA_READY          (MAC_DATA_READY),
    .MAC_DATA_LAST           (MAC_DATA_LAST),
    .MAC_DATA_TUSER          (MAC_DATA_TUSER),
    .DATA_FRAME              (DATA_FRAME),
    .SRC_IP_ADDRESS          (SRC_IP_ADDRESS),
    .SRC_MAC_ADDRESS         (SRC_MAC_ADDRESS),
    .FRAME_VALID             (FRAME_VALID),
    .FRAME_READY             (FRAME_READY),
    .PKT_COUNT               (PKT_COUNT),
    .DROP_COUNT              (DROP_COUNT)
  );

  int                         vectorsApplied = 0;
  int                         miscompares    = 0;
  int                         stallCount     = 0;
  bit                         linkDead       = 1'b0;
  int                         expPkt         = 0;
  int                         expDrop        = 0;
  byteQ_t                     txPkt;
  logic [8*PAYLOAD_BYTES-1:0] expFrame;
  logic [8*PAYLOAD_BYTES-1:0] heldFrame;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Builds an ETH+IPv4 packet into txPkt with random sender fields and payload
  task automatic buildPkt(input logic [47:0] dstMac, input logic [15:0] etherType,
                          input logic [31:0] dstIp, input int payLen, input bit badCsum);
    logic [47:0] srcMac;
    logic [31:0] srcIp;
    logic [15:0] totLen;
    logic [31:0] s;
    logic [15:0] csum;
    srcMac = {16'($urandom), 32'($urandom)};
    srcIp  = $urandom;
    totLen = 16'(20 + payLen);
    txPkt.delete();
    for (int i = 0; i < 6; i++) txPkt.push_back(dstMac[8*(5-i) +: 8]);
    for (int i = 0; i < 6; i++) txPkt.push_back(srcMac[8*(5-i) +: 8]);
    txPkt.push_back(etherType[15:8]);
    txPkt.push_back(etherType[7:0]);
    txPkt.push_back(8'h45); txPkt.push_back(8'h00);
    txPkt.push_back(totLen[15:8]); txPkt.push_back(totLen[7:0]);
    txPkt.push_back(8'($urandom)); txPkt.push_back(8'($urandom));
    txPkt.push_back(8'h00); txPkt.push_back(8'h00);
    txPkt.push_back(8'd64); txPkt.push_back(8'd17);
    txPkt.push_back(8'h00); txPkt.push_back(8'h00);
    for (int i = 0; i < 4; i++) txPkt.push_back(srcIp[8*(3-i) +: 8]);
    for (int i = 0; i < 4; i++) txPkt.push_back(dstIp[8*(3-i) +: 8]);
    s = 0;
    for (int w = 0; w < 10; w++) s = s + {16'd0, txPkt[14+2*w], txPkt[15+2*w]};
    while (s[31:16] != 0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    csum = ~s[15:0];
    if (badCsum) csum = csum ^ 16'h0100;
    txPkt[24] = csum[15:8];
    txPkt[25] = csum[7:0];
    for (int i = 0; i < payLen; i++) txPkt.push_back(8'($urandom));
  endtask

  // Reference model: a byte stream delivered from IDLE is accepted exactly
  // when it is a full-length packet that passes every filter with tuser clear
  function automatic bit modelAccepts(input byteQ_t p, input logic user);
    logic [47:0] dm;
    logic [31:0] di;
    logic [31:0] s;
    if (p.size() != PKT_BYTES) return 1'b0;
    if (user) return 1'b0;
    dm = {p[0], p[1], p[2], p[3], p[4], p[5]};
    if (dm != ownMac && dm != 48'hFFFF_FFFF_FFFF) return 1'b0;
    if ({p[12], p[13]} != 16'h0800) return 1'b0;
    di = {p[30], p[31], p[32], p[33]};
    if (di != ownIp) return 1'b0;
`ifdef IP_RX_CSUM_CHECK_EN
    s = 0;
    for (int w = 0; w < 10; w++) s = s + {16'd0, p[14+2*w], p[15+2*w]};
    while (s[31:16] != 0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    if (s[15:0] != 16'hFFFF) return 1'b0;
`else
    s = 0;
`endif
    return 1'b1;
  endfunction

  // One AXI-S beat; entered and left at posedge+1
  task automatic driveBeat(input logic [7:0] d, input logic last, input logic user);
    int waited;
    if (linkDead) return;
    if ($urandom_range(0, 7) == 0) begin
      MAC_DATA_VALID = 1'b0;
      @(posedge ACLK); #1;
    end
    MAC_DATA_VALID = 1'b1;
    MAC_DATA_OUT   = d;
    MAC_DATA_LAST  = last;
    MAC_DATA_TUSER = user;
    @(negedge ACLK);
    if (MAC_DATA_READY !== 1'b1) stallCount++;
    waited = 0;
    while (MAC_DATA_READY !== 1'b1 && waited < 300) begin
      @(negedge ACLK);
      waited++;
    end
    if (MAC_DATA_READY !== 1'b1) begin
      checkOutput("beat_ready_timeout", {63'd0, MAC_DATA_READY}, 64'd1);
      linkDead       = 1'b1;
      MAC_DATA_VALID = 1'b0;
      return;
    end
    @(posedge ACLK); #1;
    MAC_DATA_VALID = 1'b0;
    MAC_DATA_LAST  = 1'b0;
    MAC_DATA_TUSER = 1'b0;
  endtask

  task automatic applyStimulus(input int startIdx, input int endIdx, input bit lastAtEnd, input bit user);
    for (int i = startIdx; i <= endIdx; i++)
      driveBeat(txPkt[i], lastAtEnd && (i == endIdx), lastAtEnd && (i == endIdx) && user);
  endtask

  // Streams txPkt[startIdx..] as one packet and checks the outcome
  task automatic sendAndCheck(input int startIdx, input bit user, input string tag);
    byteQ_t sub;
    bit     acc;
    int     badBytes;
    for (int i = startIdx; i < txPkt.size(); i++) sub.push_back(txPkt[i]);
    applyStimulus(startIdx, txPkt.size() - 1, 1'b1, user);
    acc = modelAccepts(sub, user);
    if (acc) begin
      if (expPkt < CNT_MAX) expPkt++;
      for (int i = 0; i < PAYLOAD_BYTES; i++) expFrame[8*i +: 8] = sub[HDR_BYTES + i];
    end else if (expDrop < CNT_MAX) begin
      expDrop++;
    end
    checkOutput({tag, "_frame_valid"}, {63'd0, FRAME_VALID}, {63'd0, acc});
    checkOutput({tag, "_pkt_count"},  64'(PKT_COUNT),  64'(expPkt));
    checkOutput({tag, "_drop_count"}, 64'(DROP_COUNT), 64'(expDrop));
    if (acc) begin
      badBytes = 0;
      for (int i = 0; i < PAYLOAD_BYTES; i++)
        if (DATA_FRAME[8*i +: 8] !== expFrame[8*i +: 8]) badBytes++;
      checkOutput({tag, "_frame_bad_bytes"}, 64'(badBytes), 64'd0);
      checkOutput({tag, "_frame_byte0"}, 64'(DATA_FRAME[7:0]), 64'(sub[HDR_BYTES]));
      checkOutput({tag, "_src_mac"}, 64'(SRC_MAC_ADDRESS),
                  64'({sub[6], sub[7], sub[8], sub[9], sub[10], sub[11]}));
      checkOutput({tag, "_src_ip"}, 64'(SRC_IP_ADDRESS), 64'({sub[26], sub[27], sub[28], sub[29]}));
      if (FRAME_READY) begin
        @(posedge ACLK); #1;
        checkOutput({tag, "_frame_valid_fall"}, {63'd0, FRAME_VALID}, 64'd0);
      end
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_frame_valid"}, {63'd0, FRAME_VALID}, 64'd0);
    checkOutput({tag, "_mac_ready"},   {63'd0, MAC_DATA_READY}, 64'd0);
    checkOutput({tag, "_pkt_count"},   64'(PKT_COUNT), 64'd0);
    checkOutput({tag, "_drop_count"},  64'(DROP_COUNT), 64'd0);
  endtask

  // Watchdog so a stuck design still ends the run
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int kind;
    int badBytes;
    logic [47:0] dmac;
    logic [31:0] dip;
    logic [15:0] etype;
    int payLen;
    bit badCs;
    bit user;

    ARESET         = 1'b1;
    MAC_DATA_OUT   = 8'h00;
    MAC_DATA_VALID = 1'b0;
    MAC_DATA_LAST  = 1'b0;
    MAC_DATA_TUSER = 1'b0;
    FRAME_READY    = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    checkResetState("reset");
    ARESET = 1'b0;
    @(posedge ACLK); #1;

    // Valid unicast packet
    buildPkt(ownMac, 16'h0800, ownIp, PAYLOAD_BYTES, 1'b0);
    sendAndCheck(0, 1'b0, "unicast");

    // Foreign destination MAC is drained without backpressure
    stallCount = 0;
    buildPkt(48'h0200_0000_0099, 16'h0800, ownIp, PAYLOAD_BYTES, 1'b0);
    sendAndCheck(0, 1'b0, "bad_mac");
    checkOutput("bad_mac_stalls", 64'(stallCount), 64'd0);

    // Short and long payloads
    buildPkt(ownMac, 16'h0800, ownIp, 700, 1'b0);
    sendAndCheck(0, 1'b0, "short_pay");
    buildPkt(ownMac, 16'h0800, ownIp, 790, 1'b0);
    sendAndCheck(0, 1'b0, "long_pay");

    // Bad-frame flag on tlast, then broadcast destination
    buildPkt(ownMac, 16'h0800, ownIp, PAYLOAD_BYTES, 1'b0);
    sendAndCheck(0, 1'b1, "tuser");
    buildPkt(48'hFFFF_FFFF_FFFF, 16'h0800, ownIp, PAYLOAD_BYTES, 1'b0);
    sendAndCheck(0, 1'b0, "bcast");

    // Accelerator stalls: a held frame blocks the next packet
    FRAME_READY = 1'b0;
    buildPkt(ownMac, 16'h0800, ownIp, PAYLOAD_BYTES, 1'b0);
    sendAndCheck(0, 1'b0, "held_a");
    heldFrame = expFrame;
    buildPkt(ownMac, 16'h0800, ownIp, PAYLOAD_BYTES, 1'b0);
    fork
      sendAndCheck(0, 1'b0, "held_b");
      begin
        repeat (50) @(negedge ACLK);
        checkOutput("hold_mac_ready", {63'd0, MAC_DATA_READY}, 64'd0);
        checkOutput("hold_frame_valid", {63'd0, FRAME_VALID}, 64'd1);
        badBytes = 0;
        for (int i = 0; i < PAYLOAD_BYTES; i++)
          if (DATA_FRAME[8*i +: 8] !== heldFrame[8*i +: 8]) badBytes++;
        checkOutput("hold_frame_bad_bytes", 64'(badBytes), 64'd0);
        FRAME_READY = 1'b1;
        @(posedge ACLK); #1;
        checkOutput("hold_release_fall", {63'd0, FRAME_VALID}, 64'd0);
      end
    join

    // Reset in the middle of the payload; the tail arrives as a new packet
    buildPkt(ownMac, 16'h0800, ownIp, PAYLOAD_BYTES, 1'b0);
    applyStimulus(0, HDR_BYTES + 299, 1'b0, 1'b0);
    ARESET = 1'b1;
    #1;
    checkResetState("mid_reset");
    repeat (2) @(posedge ACLK);
    #1;
    ARESET  = 1'b0;
    expPkt  = 0;
    expDrop = 0;
    sendAndCheck(HDR_BYTES + 300, 1'b0, "reset_tail");
    buildPkt(ownMac, 16'h0800, ownIp, PAYLOAD_BYTES, 1'b0);
    sendAndCheck(0, 1'b0, "after_reset");

    // Randomized mix of good and faulty packets
    for (int n = 0; n < 14; n++) begin
      kind   = $urandom_range(0, 8);
      dmac   = ownMac;
      etype  = 16'h0800;
      dip    = ownIp;
      payLen = PAYLOAD_BYTES;
      badCs  = 1'b0;
      user   = 1'b0;
      case (kind)
        1: dmac   = 48'hFFFF_FFFF_FFFF;
        2: dmac   = ownMac ^ (48'd1 << $urandom_range(0, 47));
        3: etype  = 16'h86DD;
        4: dip    = ownIp ^ (32'd1 << $urandom_range(0, 31));
        5: payLen = $urandom_range(1, PAYLOAD_BYTES - 1);
        6: payLen = $urandom_range(PAYLOAD_BYTES + 1, PAYLOAD_BYTES + 15);
        7: begin
             user  = $urandom_range(0, 1) == 1;
             badCs = !user;
           end
        default: ;
      endcase
      buildPkt(dmac, etype, dip, payLen, badCs);
      if (kind == 8) begin
        payLen = $urandom_range(1, HDR_BYTES - 1);
        while (txPkt.size() > payLen) void'(txPkt.pop_back());
      end
      sendAndCheck(0, user, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
